timekeeper_alarm_ctrl: RTL and testbench

//  Time-of-day counter (hh:mm:ss, 24 h) with built-in set/edit FSM and NUM_ALARMS dose-alarm slots.

---
 rtl/timekeeper_alarm_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_timekeeper_alarm_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timekeeper_alarm_ctrl.sv
// 24-hour time-of-day counter with a set/edit FSM and NUM_ALARMS dose-alarm slots.
// Drives the HEX display time bus and raises sticky per-slot dispense requests.
module timekeeper_alarm_ctrl #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int NUM_ALARMS    = 4,
   parameter int SEL_W         = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  set,
   input  logic                  incHours,
   input  logic                  incMinutes,
   input  logic                  incSeconds,
   input  logic                  alarm_wr,
   input  logic [SEL_W-1:0]      alarm_sel,
   input  logic                  alarm_en_in,
   input  logic [4:0]            alarm_hours,
   input  logic [5:0]            alarm_minutes,
   input  logic [NUM_ALARMS-1:0] alarm_ack,
   output logic [4:0]            outhours,
   output logic [5:0]            outminutes,
   output logic [5:0]            outseconds,
   output logic                  sec_tick,
   output logic                  editing,
   output logic [NUM_ALARMS-1:0] alarm_due,
   output logic [NUM_ALARMS-1:0] alarm_pending,
   output logic                  dispense_req
);

   localparam int               CNT_W    = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {S_CLOCK, S_PRESET, S_SET, S_UPDATE} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  tick;
   logic [4:0]            hh_q, hh_d, hh_adv;
   logic [5:0]            mm_q, mm_d, mm_adv;
   logic [5:0]            ss_q, ss_d, ss_adv;
   logic [4:0]            ehh_q, ehh_d;
   logic [5:0]            emm_q, emm_d;
   logic [5:0]            ess_q, ess_d;
   logic [2:0]            btn_q, btn_now, btn_fall;
   logic [4:0]            dhh_q, dhh_d;
   logic [5:0]            dmm_q, dmm_d;
   logic [5:0]            dss_q, dss_d;
   logic                  editing_q;
   logic [NUM_ALARMS-1:0] match;
   logic [NUM_ALARMS-1:0] due_q;
   logic [NUM_ALARMS-1:0] pend_q, pend_d;
   logic [NUM_ALARMS-1:0] alm_en_q;
   logic [4:0]            alm_hh_q [NUM_ALARMS];
   logic [5:0]            alm_mm_q [NUM_ALARMS];

   assign tick     = (cnt_q == CNT_LAST);
   assign btn_now  = {incHours, incMinutes, incSeconds};
   assign btn_fall = btn_q & ~btn_now;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      if (state_q == S_UPDATE) begin
         cnt_d = '0;
      end
   end

   // Live time one second ahead, used both for the tick update and for alarm matching.
   always_comb begin
      ss_adv = ss_q + 6'd1;
      mm_adv = mm_q;
      hh_adv = hh_q;
      if (ss_q == 6'd59) begin
         ss_adv = 6'd0;
         mm_adv = mm_q + 6'd1;
         if (mm_q == 6'd59) begin
            mm_adv = 6'd0;
            hh_adv = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
         end
      end
   end

   always_comb begin
      hh_d = hh_q;
      mm_d = mm_q;
      ss_d = ss_q;
      if (state_q == S_UPDATE) begin
         hh_d = ehh_q;
         mm_d = emm_q;
         ss_d = ess_q;
      end else if (tick) begin
         hh_d = hh_adv;
         mm_d = mm_adv;
         ss_d = ss_adv;
      end
   end

   always_comb begin
      ehh_d = ehh_q;
      emm_d = emm_q;
      ess_d = ess_q;
      if (state_q == S_PRESET) begin
         ehh_d = hh_q;
         emm_d = mm_q;
         ess_d = ss_q;
      end else if (state_q == S_SET) begin
         if (btn_fall[2]) ehh_d = (ehh_q == 5'd23) ? 5'd0 : ehh_q + 5'd1;
         if (btn_fall[1]) emm_d = (emm_q == 6'd59) ? 6'd0 : emm_q + 6'd1;
         if (btn_fall[0]) ess_d = (ess_q == 6'd59) ? 6'd0 : ess_q + 6'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_CLOCK:  if (set) state_d = S_PRESET;
         S_PRESET: state_d = S_SET;
         S_SET:    if (!set) state_d = S_UPDATE;
         S_UPDATE: state_d = S_CLOCK;
         default:  state_d = S_CLOCK;
      endcase
   end

   always_comb begin
      dhh_d = hh_q;
      dmm_d = mm_q;
      dss_d = ss_q;
      if (state_q == S_SET || state_q == S_UPDATE) begin
         dhh_d = ehh_q;
         dmm_d = emm_q;
         dss_d = ess_q;
      end
   end

   // Only a tick-driven advance can fire an alarm; an UPDATE load never does.
   always_comb begin
      match = '0;
      if (tick && state_q != S_UPDATE && ss_adv == 6'd0) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (alm_en_q[i] && alm_hh_q[i] == hh_adv && alm_mm_q[i] == mm_adv) begin
               match[i] = 1'b1;
            end
         end
      end
   end

   assign pend_d = (pend_q & ~alarm_ack) | match;

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_CLOCK;
         cnt_q     <= '0;
         hh_q      <= '0;
         mm_q      <= '0;
         ss_q      <= '0;
         ehh_q     <= '0;
         emm_q     <= '0;
         ess_q     <= '0;
         btn_q     <= 3'b111;
         dhh_q     <= '0;
         dmm_q     <= '0;
         dss_q     <= '0;
         editing_q <= 1'b0;
         due_q     <= '0;
         pend_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hh_q      <= hh_d;
         mm_q      <= mm_d;
         ss_q      <= ss_d;
         ehh_q     <= ehh_d;
         emm_q     <= emm_d;
         ess_q     <= ess_d;
         btn_q     <= btn_now;
         dhh_q     <= dhh_d;
         dmm_q     <= dmm_d;
         dss_q     <= dss_d;
         editing_q <= (state_d != S_CLOCK);
         due_q     <= match;
         pend_q    <= pend_d;
      end
   end

   // NOTE: the slot table is small and must power up disabled, so it is reset like any register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         alm_en_q <= '0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            alm_hh_q[i] <= '0;
            alm_mm_q[i] <= '0;
         end
      end else if (alarm_wr) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (alarm_sel == SEL_W'(i)) begin
               alm_en_q[i] <= alarm_en_in;
               alm_hh_q[i] <= alarm_hours;
               alm_mm_q[i] <= alarm_minutes;
            end
         end
      end
   end

   assign outhours      = dhh_q;
   assign outminutes    = dmm_q;
   assign outseconds    = dss_q;
   assign sec_tick      = tick;
   assign editing       = editing_q;
   assign alarm_due     = due_q;
   assign alarm_pending = pend_q;
   assign dispense_req  = |pend_q;

endmodule

// File: tb/tb_timekeeper_alarm_ctrl.sv
// Scoreboard bench for timekeeper_alarm_ctrl: a seconds-of-day reference model predicts
// every tick, alarm pulse and edit result; a separate monitor compares them against the DUT.
module tb_timekeeper_alarm_ctrl;

   localparam int T  = 4;
   localparam int NA = 4;
   localparam int MD_CLOCK = 0, MD_PRESET = 1, MD_SET = 2, MD_UPDATE = 3;

   logic       clock = 1'b0;
   logic       reset;
   logic       set_s, inc_h, inc_m, inc_s, wr, en_in;
   logic [1:0] sel;
   logic [4:0] ah;
   logic [5:0] am;
   logic [3:0] ack;
   logic [4:0] outhours;
   logic [5:0] outminutes, outseconds;
   logic       sec_tick, editing, dispense_req;
   logic [3:0] alarm_due, alarm_pending;

   timekeeper_alarm_ctrl #(.TICKS_PER_SEC(T), .NUM_ALARMS(NA), .SEL_W(2)) dut (
      .clock(clock), .reset(reset), .set(set_s),
      .incHours(inc_h), .incMinutes(inc_m), .incSeconds(inc_s),
      .alarm_wr(wr), .alarm_sel(sel), .alarm_en_in(en_in),
      .alarm_hours(ah), .alarm_minutes(am), .alarm_ack(ack),
      .outhours(outhours), .outminutes(outminutes), .outseconds(outseconds),
      .sec_tick(sec_tick), .editing(editing), .alarm_due(alarm_due),
      .alarm_pending(alarm_pending), .dispense_req(dispense_req)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_tests = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (time as seconds of day) ----------------
   typedef struct {
      int         cyc;
      bit         check_time;
      int         sod;
      logic [3:0] due;
      logic [3:0] pend;
   } tick_rec_t;

   tick_rec_t  exp_q[$];
   int         ed_q[$];
   bit         mon_en = 1'b0;

   int         m_pcnt, m_sod, m_mode, m_eh, m_em, m_es;
   bit   [2:0] m_prev;
   bit         m_en[NA];
   int         m_ah[NA], m_am[NA];
   logic [3:0] m_pend;

   task automatic model_reset();
      m_pcnt = 0; m_sod = 0; m_mode = MD_CLOCK;
      m_eh = 0; m_em = 0; m_es = 0; m_prev = 3'b111; m_pend = '0;
      for (int i = 0; i < NA; i++) begin
         m_en[i] = 0; m_ah[i] = 0; m_am[i] = 0;
      end
   endtask

   task automatic model_step();
      bit         tick;
      int         nsod;
      logic [3:0] match;
      bit   [2:0] cur, fall;
      tick_rec_t  r;
      tick  = (m_pcnt == T - 1);
      cur   = {inc_h, inc_m, inc_s};
      fall  = m_prev & ~cur;
      match = '0;
      if (m_mode == MD_UPDATE) begin
         nsod   = m_eh * 3600 + m_em * 60 + m_es;
         m_pcnt = 0;
      end else begin
         nsod   = tick ? (m_sod + 1) % 86400 : m_sod;
         m_pcnt = tick ? 0 : m_pcnt + 1;
         if (tick && nsod % 60 == 0)
            for (int i = 0; i < NA; i++)
               if (m_en[i] && m_ah[i] == nsod / 3600 && m_am[i] == (nsod / 60) % 60)
                  match[i] = 1'b1;
      end
      m_pend = (m_pend & ~ack) | match;
      if (tick) begin
         r.cyc = cyc; r.check_time = (m_mode == MD_CLOCK); r.sod = nsod;
         r.due = match; r.pend = m_pend;
         exp_q.push_back(r);
      end
      case (m_mode)
         MD_CLOCK:  if (set_s) m_mode = MD_PRESET;
         MD_PRESET: begin
            m_eh = m_sod / 3600; m_em = (m_sod / 60) % 60; m_es = m_sod % 60;
            m_mode = MD_SET;
         end
         MD_SET: begin
            if (fall[2]) m_eh = (m_eh + 1) % 24;
            if (fall[1]) m_em = (m_em + 1) % 60;
            if (fall[0]) m_es = (m_es + 1) % 60;
            if (!set_s) m_mode = MD_UPDATE;
         end
         default: begin
            ed_q.push_back(m_eh * 3600 + m_em * 60 + m_es);
            m_mode = MD_CLOCK;
         end
      endcase
      m_sod = nsod;
      if (wr && int'(sel) < NA) begin
         m_en[sel] = en_in; m_ah[sel] = ah; m_am[sel] = am;
      end
      m_prev = cur;
   endtask

   // One clock cycle: the model consumes the current inputs, then time moves past the edge.
   task automatic cycle();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic quiet();
      set_s = 0; inc_h = 1; inc_m = 1; inc_s = 1; wr = 0; ack = '0;
      en_in = 0; sel = '0; ah = '0; am = '0;
   endtask

   task automatic do_reset();
      mon_en = 0;
      quiet();
      reset = 0;
      model_reset();
      exp_q.delete();
      ed_q.delete();
      @(posedge clock);
      #1;
      check("rst_hours", outhours, 0);
      check("rst_minutes", outminutes, 0);
      check("rst_seconds", outseconds, 0);
      check("rst_sec_tick", sec_tick, 0);
      check("rst_editing", editing, 0);
      check("rst_due", alarm_due, 0);
      check("rst_pending", alarm_pending, 0);
      check("rst_dispense", dispense_req, 0);
      reset = 1;
      mon_en = 1;
   endtask

   // Enter edit mode, step each field to its target with button presses, then leave.
   task automatic set_time(input int h, input int m, input int s);
      int nh, nm, ns, n;
      quiet();
      for (int j = 0; j < 8 && m_mode != MD_CLOCK; j++) cycle();
      set_s = 1;
      cycle();
      cycle();
      check("editing_in_set", editing, 1);
      nh = (h - m_eh + 24) % 24;
      nm = (m - m_em + 60) % 60;
      ns = (s - m_es + 60) % 60;
      n  = (nh > nm) ? nh : nm;
      n  = (ns > n) ? ns : n;
      for (int k = 0; k < n; k++) begin
         inc_h = !(k < nh); inc_m = !(k < nm); inc_s = !(k < ns);
         cycle();
         inc_h = 1; inc_m = 1; inc_s = 1;
         cycle();
      end
      set_s = 0;
      cycle();
      cycle();
   endtask

   task automatic short_edit();
      int k;
      k = $urandom_range(1, 12);
      wr = 0; ack = '0; set_s = 1;
      for (int j = 0; j < k; j++) begin
         inc_h = 1'($urandom_range(0, 1));
         inc_m = 1'($urandom_range(0, 1));
         inc_s = 1'($urandom_range(0, 1));
         cycle();
      end
      quiet();
      for (int j = 0; j < 6 && m_mode != MD_CLOCK; j++) cycle();
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      tick_rec_t cur;
      int        stage;
      bit        ed_prev;
      int        e;
      stage = 0;
      ed_prev = 0;
      forever begin
         @(negedge clock);
         if (!mon_en) begin
            stage = 0;
            ed_prev = editing;
         end else begin
            if (stage == 1) begin
               if (cur.check_time) begin
                  check("tick_hours", outhours, cur.sod / 3600);
                  check("tick_minutes", outminutes, (cur.sod / 60) % 60);
                  check("tick_seconds", outseconds, cur.sod % 60);
               end
               stage = 0;
            end
            if (stage == 2) begin
               check("due", alarm_due, cur.due);
               check("pending", alarm_pending, cur.pend);
               check("dispense_req", dispense_req, |cur.pend);
               stage = 1;
            end else begin
               check("due_idle", alarm_due, 0);
            end
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
               cur = exp_q.pop_front();
               check("sec_tick", sec_tick, 1);
               stage = 2;
            end else begin
               check("sec_tick_idle", sec_tick, 0);
            end
            if (ed_prev && !editing) begin
               check("edit_record_present", ed_q.size() != 0, 1);
               if (ed_q.size() != 0) begin
                  e = ed_q.pop_front();
                  check("edit_hours", outhours, e / 3600);
                  check("edit_minutes", outminutes, (e / 60) % 60);
                  check("edit_seconds", outseconds, e % 60);
               end
            end
            ed_prev = editing;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      int r;
      bit hit;
      do_reset();

      // First second after reset: tick in cycle 3, seconds visible two cycles later.
      for (int j = 0; j < 5; j++) cycle();
      check("first_second", outseconds, 1);

      // Day rollover and hour carry.
      set_time(23, 59, 58);
      for (int j = 0; j < 10; j++) cycle();
      check("rollover_h", outhours, 0);
      check("rollover_m", outminutes, 0);
      check("rollover_s", outseconds, 0);
      set_time(0, 59, 59);
      for (int j = 0; j < 6; j++) cycle();
      check("carry_h", outhours, 1);
      check("carry_m", outminutes, 0);
      check("carry_s", outseconds, 0);

      // Edit from 10:20:30: three minute presses and one hour press.
      set_time(10, 20, 30);
      set_s = 1; cycle(); cycle();
      inc_m = 0; inc_h = 0; cycle(); inc_m = 1; inc_h = 1; cycle();
      inc_m = 0; cycle(); inc_m = 1; cycle();
      inc_m = 0; cycle(); inc_m = 1; cycle();
      set_s = 0; cycle(); cycle();
      check("edit_result_h", outhours, 11);
      check("edit_result_m", outminutes, 23);
      check("edit_result_s", outseconds, 30);
      cycle(); cycle(); cycle();
      check("prescaler_restart", sec_tick, 1);

      // Buttons in CLOCK are ignored.
      for (int j = 0; j < 6; j++) begin
         inc_h = j[0]; inc_m = j[0]; inc_s = j[0];
         cycle();
      end
      quiet();
      check("clock_buttons_h", outhours, 11);
      check("clock_buttons_m", outminutes, 23);
      check("clock_buttons_s", outseconds, 32);

      // Seconds wrap in edit without carrying into minutes.
      set_time(12, 34, 59);
      set_s = 1; cycle(); cycle();
      inc_s = 0; cycle(); inc_s = 1; cycle();
      set_s = 0; cycle(); cycle();
      check("wrap_m", outminutes, 34);
      check("wrap_s", outseconds, 0);

      // Two enabled slots at 08:00, a disabled one, and an out-of-range hour.
      wr = 1; en_in = 1; ah = 8;  am = 0; sel = 2; cycle();
      sel = 0; cycle();
      en_in = 0; sel = 1; cycle();
      en_in = 1; ah = 24; sel = 3; cycle();
      quiet();
      set_time(7, 59, 57);
      hit = 0;
      for (int j = 0; j < 40 && !hit; j++) begin
         cycle();
         hit = (m_sod == 8 * 3600);
      end
      check("reach_0800", hit, 1);
      check("due_0101", alarm_due, 4'b0101);
      check("pending_0101", alarm_pending, 4'b0101);
      check("dispense_on", dispense_req, 1);
      ack = 4'b0001; cycle(); ack = '0;
      check("ack0_pending", alarm_pending, 4'b0100);
      wr = 1; en_in = 1; ah = 8; am = 1; sel = 2; cycle(); quiet();
      check("write_keeps_pending", alarm_pending, 4'b0100);

      // Match and ack in the same cycle: the set wins.
      hit = 0;
      for (int j = 0; j < 300 && !hit; j++) begin
         ack = (m_pcnt == T - 1 && m_sod == 8 * 3600 + 59) ? 4'b0100 : 4'b0000;
         cycle();
         hit = (m_sod == 8 * 3600 + 60);
      end
      ack = '0;
      check("reach_0801", hit, 1);
      check("due_set_wins", alarm_due, 4'b0100);
      check("pending_set_wins", alarm_pending, 4'b0100);

      // Loading 08:00:00 through UPDATE must not fire slot 0.
      ack = 4'b0100; cycle(); ack = '0;
      set_time(8, 0, 0);
      check("update_no_pending", alarm_pending, 0);
      for (int j = 0; j < 6; j++) cycle();
      check("update_no_pending_later", alarm_pending, 0);

      // Randomized traffic.
      for (int it = 0; it < 2500; it++) begin
         r = $urandom_range(0, 299);
         if (r == 0) begin
            set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(50, 59));
         end else if (r == 1) begin
            short_edit();
         end else begin
            wr    = ($urandom_range(0, 9) == 0);
            sel   = 2'($urandom_range(0, 3));
            en_in = ($urandom_range(0, 3) != 0);
            ah    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31)) : 5'(m_sod / 3600);
            am    = 6'(((m_sod / 60) + $urandom_range(0, 2)) % 60);
            ack   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            inc_h = ($urandom_range(0, 3) != 0);
            inc_m = ($urandom_range(0, 3) != 0);
            inc_s = ($urandom_range(0, 3) != 0);
            cycle();
         end
      end
      quiet();
      for (int j = 0; j < 6; j++) cycle();

      // Reset in the middle of an edit.
      set_s = 1; cycle(); cycle();
      inc_h = 0; cycle(); inc_h = 1; cycle();
      do_reset();
      for (int j = 0; j < 5; j++) cycle();
      check("post_reset_h", outhours, 0);
      check("post_reset_m", outminutes, 0);
      check("post_reset_s", outseconds, 1);
      for (int j = 0; j < 8; j++) cycle();

      check("tick_queue_drained", exp_q.size(), 0);
      check("edit_queue_drained", ed_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
